// File: rtl/secport_pkg.sv
// Shared address map, CTRL/STATUS bit positions and the access decoder for secport.
package secport_pkg;

  localparam int unsigned RAM_TOP          = 32'h1EF;
  localparam int unsigned PORT_OUT_ADDR    = 32'h1F0;
  localparam int unsigned PORT_IN_ADDR     = 32'h1F1;
  localparam int unsigned TIMER_RELOAD_ADDR = 32'h1F2;
  localparam int unsigned TIMER_COUNT_ADDR = 32'h1F3;
  localparam int unsigned CTRL_ADDR        = 32'h1F4;
  localparam int unsigned STATUS_ADDR      = 32'h1F5;
  localparam int unsigned WP_BASE_ADDR     = 32'h1F6;
  localparam int unsigned WP_LIMIT_ADDR    = 32'h1F7;

  localparam int unsigned CTRL_TIMER_EN = 0;
  localparam int unsigned CTRL_INT_EN   = 1;
  localparam int unsigned CTRL_WP_LOCK  = 2;
  localparam int unsigned STAT_TIMER    = 0;
  localparam int unsigned STAT_FAULT    = 1;

  typedef enum logic [3:0] {
    SelRam,
    SelPortOut,
    SelPortIn,
    SelReload,
    SelCount,
    SelCtrl,
    SelStatus,
    SelWpBase,
    SelWpLimit,
    SelUnmapped
  } sel_e;

  function automatic sel_e decode_addr(input int unsigned addr, input int unsigned ram_words);
    sel_e sel;
    if (addr < ram_words) begin
      sel = SelRam;
    end else begin
      case (addr)
        PORT_OUT_ADDR:     sel = SelPortOut;
        PORT_IN_ADDR:      sel = SelPortIn;
        TIMER_RELOAD_ADDR: sel = SelReload;
        TIMER_COUNT_ADDR:  sel = SelCount;
        CTRL_ADDR:         sel = SelCtrl;
        STATUS_ADDR:       sel = SelStatus;
        WP_BASE_ADDR:      sel = SelWpBase;
        WP_LIMIT_ADDR:     sel = SelWpLimit;
        default:           sel = SelUnmapped;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/sectimer.sv
// Reload down-counter: expires when enabled at zero, reloading and pulsing expire.
module sectimer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  logic [WIDTH-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);
  // A load in the same cycle suppresses both the decrement and the expiry.
  assign expire = en & ~load & w_zero;
  assign count  = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (en) begin
      r_count <= w_zero ? reload : r_count - 1'b1;
    end
  end

endmodule

// File: rtl/secport.sv
// CPU data-port controller: RAM plus memory-mapped port, timer, control/status
// and lockable write-protect registers, with a level interrupt output.
module secport
  import secport_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = 9,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RAM_WORDS  = 496
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_DEPTH-1:0] data_address,
  input  logic                  read_strobe,
  input  logic                  write_strobe,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] port_in,
  output logic [DATA_WIDTH-1:0] port_out,
  output logic                  intr
);

  logic [DATA_WIDTH-1:0] r_ram [RAM_WORDS];
  logic [DATA_WIDTH-1:0] r_port_out;
  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_reload;
  logic [DATA_WIDTH-1:0] r_wp_base;
  logic [DATA_WIDTH-1:0] r_wp_limit;
  logic [2:0]            r_ctrl;
  logic                  r_tpend;
  logic                  r_fpend;

  sel_e                  w_sel;
  logic                  w_locked;
  logic                  w_in_window;
  logic                  w_ram_we;
  logic                  w_wr_reload;
  logic                  w_wr_ctrl;
  logic                  w_wr_status;
  logic                  w_fault_set;
  logic                  w_expire;
  logic [DATA_WIDTH-1:0] w_count;

  assign w_sel    = decode_addr(32'(data_address), RAM_WORDS);
  assign w_locked = r_ctrl[CTRL_WP_LOCK];
  // Unsigned window; base > limit naturally yields an empty window.
  assign w_in_window = (32'(data_address) >= 32'(r_wp_base)) &&
                       (32'(data_address) <= 32'(r_wp_limit));

  assign w_ram_we    = write_strobe && (w_sel == SelRam) && !(w_locked && w_in_window);
  assign w_wr_reload = write_strobe && (w_sel == SelReload);
  assign w_wr_ctrl   = write_strobe && (w_sel == SelCtrl);
  assign w_wr_status = write_strobe && (w_sel == SelStatus);

  always_comb begin
    w_fault_set = 1'b0;
    if (write_strobe) begin
      unique case (w_sel)
        SelRam:                w_fault_set = w_locked && w_in_window;
        SelWpBase, SelWpLimit: w_fault_set = w_locked;
        SelCtrl:               w_fault_set = w_locked && !wdata[CTRL_WP_LOCK];
        SelUnmapped:           w_fault_set = 1'b1;
        default:               w_fault_set = 1'b0;
      endcase
    end
  end

  sectimer #(
    .WIDTH(DATA_WIDTH)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .en        (r_ctrl[CTRL_TIMER_EN]),
    .load      (w_wr_reload),
    .load_value(wdata),
    .reload    (r_reload),
    .count     (w_count),
    .expire    (w_expire)
  );

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[data_address] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_reload   <= '0;
      r_wp_base  <= '0;
      r_wp_limit <= '0;
      r_ctrl     <= '0;
      r_tpend    <= 1'b0;
      r_fpend    <= 1'b0;
    end else begin
      r_sync1 <= port_in;
      r_sync2 <= r_sync1;
      if (write_strobe && (w_sel == SelPortOut)) r_port_out <= wdata;
      if (w_wr_reload) r_reload <= wdata;
      if (write_strobe && (w_sel == SelWpBase) && !w_locked) r_wp_base <= wdata;
      if (write_strobe && (w_sel == SelWpLimit) && !w_locked) r_wp_limit <= wdata;
      if (w_wr_ctrl) begin
        r_ctrl[CTRL_TIMER_EN] <= wdata[CTRL_TIMER_EN];
        r_ctrl[CTRL_INT_EN]   <= wdata[CTRL_INT_EN];
        r_ctrl[CTRL_WP_LOCK]  <= w_locked | wdata[CTRL_WP_LOCK];
      end
      // New events override a simultaneous write-1-to-clear.
      r_tpend <= (r_tpend & ~(w_wr_status & wdata[STAT_TIMER])) | w_expire;
      r_fpend <= (r_fpend & ~(w_wr_status & wdata[STAT_FAULT])) | w_fault_set;
    end
  end

  always_comb begin
    rdata = '0;
    if (read_strobe) begin
      unique case (w_sel)
        SelRam:      rdata = r_ram[data_address];
        SelPortOut:  rdata = r_port_out;
        SelPortIn:   rdata = r_sync2;
        SelReload:   rdata = r_reload;
        SelCount:    rdata = w_count;
        SelCtrl:     rdata = {{(DATA_WIDTH-3){1'b0}}, r_ctrl};
        SelStatus:   rdata = {{(DATA_WIDTH-2){1'b0}}, r_fpend, r_tpend};
        SelWpBase:   rdata = r_wp_base;
        SelWpLimit:  rdata = r_wp_limit;
        default:     rdata = '0;
      endcase
    end
  end

  assign port_out = r_port_out;
  assign intr     = r_ctrl[CTRL_INT_EN] & (r_tpend | r_fpend);

endmodule
